// File: rtl/tff_mod_counter_pkg.sv
// Shared helpers for the T-flip-flop modulo counter: terminal-count decode and next-state function.
package tff_cnt_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_MOD   = 10;

  function automatic logic is_term(input int unsigned count, input logic up,
                                   input int unsigned mod);
    return up ? (count == mod - 1) : (count == 0);
  endfunction

  // sat=1 holds the count at a boundary instead of wrapping round
  function automatic int unsigned next_val(input int unsigned count, input logic up,
                                           input int unsigned mod, input logic sat);
    int unsigned nv;
    if (up) begin
      if (count == mod - 1) nv = sat ? count : 0;
      else                  nv = count + 1;
    end else begin
      if (count == 0)       nv = sat ? count : mod - 1;
      else                  nv = count - 1;
    end
    return nv;
  endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle of one counter stage; master drives controls, slave is the counter.
interface tff_mod_counter_if import tff_cnt_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (output en, up, load, load_val, input count, tc, wrap, load_err);
  modport slave  (input en, up, load, load_val, output count, tc, wrap, load_err);
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low reset to INIT.
module tff_cell #(
  parameter logic INIT = 1'b0
) (
  output logic Q,
  input  logic T,
  input  logic Clk,
  input  logic rst
);
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) Q <= INIT;
    else      Q <= Q ^ T;
  end
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter built from T flip-flops; define TFF_CNT_SAT_EN for saturating mode.
module tff_mod_counter import tff_cnt_pkg::*; #(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MOD     = DEF_MOD,
  parameter int unsigned RST_VAL = 0
) (
  input  logic                   Clk,
  input  logic                   rst,
  tff_mod_counter_if.slave       bus
);
`ifdef TFF_CNT_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d, t_vec;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             term;

  assign term = is_term(32'(count_q), bus.up, MOD);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (32'(bus.load_val) < MOD) count_d = bus.load_val;
      else                         err_d   = 1'b1;
    end else if (bus.en) begin
      count_d = WIDTH'(next_val(32'(count_q), bus.up, MOD, SAT));
      wrap_d  = term;
    end
  end

  // The count register is only reachable through toggle inputs: T = current ^ next.
  assign t_vec = count_q ^ count_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell #(.INIT(RST_BITS[i])) u_cell (
      .Q   (count_q[i]),
      .T   (t_vec[i]),
      .Clk (Clk),
      .rst (rst)
    );
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.en & ~bus.load & term;
endmodule
